// File: rtl/mem_ctrl_pkg.sv
// Shared types and default constants for the asynchronous SRAM access controller.
package mem_ctrl_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int DEFAULT_WAIT = 2;
    localparam logic [SRAM_ADDR_W-1:0] DEFAULT_IO_ADDR = 20'h0FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_DONE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        IO_DONE
    } mem_state_t;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// CPU-side request/response port of the SRAM controller.
interface sram_access_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;

    modport master (output req, we, addr, wdata, input rdata, ready, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ready, busy);
endinterface

// File: rtl/sram_access_ctrl.sv
// Turns single-cycle CPU requests into timed async-SRAM reads/writes with WAIT_CYCLES strobes.
// Optional memory-mapped I/O word (switches / hex register) enabled by defining MEM_IO_MAP_EN.
module sram_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = SRAM_ADDR_W,
    parameter int                DATA_W      = SRAM_DATA_W,
    parameter int                WAIT_CYCLES = DEFAULT_WAIT,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(DEFAULT_IO_ADDR)
) (
    input  logic               Clk,
    input  logic               Reset,
    sram_access_ctrl_if.slave  cpu,
    input  logic [DATA_W-1:0]  Switches,
    output logic [DATA_W-1:0]  hex_data,
    output logic [ADDR_W-1:0]  A,
    inout  wire  [DATA_W-1:0]  Data,
    output logic               CE_N,
    output logic               OE_N,
    output logic               WE_N,
    output logic               UB_N,
    output logic               LB_N
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_drive;
    logic              r_ce_n, r_oe_n, r_we_n;
    logic              w_accept;
    logic              w_cnt_done;
    logic              w_strobe_entry;

    // A request still held high during the ready cycle must not re-launch the finished access.
    assign w_accept       = cpu.req && !r_ready;
    assign w_cnt_done     = (r_cnt == '0);
    assign w_strobe_entry = (w_next != r_state) && (w_next == RD_STROBE || w_next == WR_STROBE);

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MEM_IO_MAP_EN
                    if (cpu.addr == IO_ADDR) w_next = IO_DONE;
                    else
`endif
                    if (cpu.we)              w_next = WR_SETUP;
                    else                     w_next = RD_STROBE;
                end
            end
            RD_STROBE: if (w_cnt_done) w_next = RD_DONE;
            WR_SETUP:  w_next = WR_STROBE;
            WR_STROBE: if (w_cnt_done) w_next = WR_HOLD;
            default:   w_next = IDLE;
        endcase
    end

    // Pins are registered from the current state, so every strobe lags its state by one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            A       <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drive <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                A       <= cpu.addr;
                r_we    <= cpu.we;
                r_wdata <= cpu.wdata;
            end
            if (w_strobe_entry)
                r_cnt <= CNT_LOAD;
            else if ((r_state == RD_STROBE || r_state == WR_STROBE) && !w_cnt_done)
                r_cnt <= r_cnt - CNT_W'(1);
            // OE_N is still low through RD_DONE, so this edge ends the last strobe cycle.
            if (r_state == RD_DONE)
                r_rdata <= Data;
`ifdef MEM_IO_MAP_EN
            if (r_state == IO_DONE && !r_we)
                r_rdata <= Switches;
`endif
            r_ce_n  <= !(r_state inside {RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD});
            r_oe_n  <= (r_state != RD_STROBE);
            r_we_n  <= (r_state != WR_STROBE);
            r_drive <= (r_state inside {WR_SETUP, WR_STROBE, WR_HOLD});
            r_ready <= (r_state inside {RD_DONE, WR_HOLD, IO_DONE});
        end
    end

`ifdef MEM_IO_MAP_EN
    logic [DATA_W-1:0] r_hex;

    always_ff @(posedge Clk) begin
        if (Reset)                             r_hex <= '0;
        else if (r_state == IO_DONE && r_we)   r_hex <= r_wdata;
    end

    assign hex_data = r_hex;
`else
    logic w_unused_io;

    assign w_unused_io = ^{Switches, r_we};
    assign hex_data    = '0;
`endif

    assign Data      = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign CE_N      = r_ce_n;
    assign UB_N      = r_ce_n;
    assign LB_N      = r_ce_n;
    assign OE_N      = r_oe_n;
    assign WE_N      = r_we_n;
    assign cpu.rdata = r_rdata;
    assign cpu.ready = r_ready;
    assign cpu.busy  = (r_state != IDLE);

endmodule
